// File: rtl/clk_divider_prog.sv
// clk_divider_prog: multi-channel programmable clock divider.
// Each channel divides clk by 2*half[i] with a 50% duty cycle and emits a
// one-cycle tick on every rising edge of its output. New half-period values
// enter via a single-entry pending slot. A value is applied only at the
// target channel's terminal count, so every output half-period is complete
// and no runt pulse is produced. If the target channel is idle, the value is
// applied at once.
module clk_divider_prog #(
  parameter  int CNT_W    = 26,
  parameter  int NUM_CH   = 2,
  parameter  int DEF_HALF = 50000000,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              load_valid,
  input  logic [CH_W-1:0]   load_ch,
  input  logic [CNT_W-1:0]  load_half,
  output logic              load_ready,
  output logic              load_err,
  output logic [NUM_CH-1:0] clkout,
  output logic [NUM_CH-1:0] tick
);

  // One extra bit so the channel-range test also works when NUM_CH is a
  // power of two (then no index can be out of range and the test is 0).
  localparam int                CHX_W      = CH_W + 1;
  localparam logic [CNT_W-1:0]  DEF_HALF_V = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0]  ONE        = CNT_W'(1);

  // A half-period of zero has no meaning; the shortest legal value is 1.
  function automatic logic [CNT_W-1:0] clamp_half(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  logic [CNT_W-1:0]  cnt  [NUM_CH];
  logic [CNT_W-1:0]  half [NUM_CH];
  logic [NUM_CH-1:0] term;
  logic [NUM_CH-1:0] apply;

  logic              pend_vld;
  logic [CH_W-1:0]   pend_ch;
  logic [CNT_W-1:0]  pend_half;

  logic              accept;
  logic              ch_bad;

  assign load_ready = ~pend_vld;
  assign accept     = load_valid & load_ready;
  assign ch_bad     = ({1'b0, load_ch} >= CHX_W'(NUM_CH));

  // Terminal-count detection and pending-value application per channel.
  always_comb begin
    term  = '0;
    apply = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      term[i]  = en[i] && (cnt[i] == (half[i] - ONE));
      apply[i] = pend_vld && (pend_ch == CH_W'(i)) && (term[i] || !en[i]);
    end
  end

  // Per-channel counter, square-wave output, rise strobe and active half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkout <= '0;
      tick   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]  <= '0;
        half[i] <= DEF_HALF_V;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        // The new value takes effect for the half-period that starts now.
        if (apply[i]) begin
          half[i] <= pend_half;
        end
        if (!en[i]) begin
          cnt[i]    <= '0;
          clkout[i] <= 1'b0;
          tick[i]   <= 1'b0;
        end else if (term[i]) begin
          cnt[i]    <= '0;
          clkout[i] <= ~clkout[i];
          tick[i]   <= ~clkout[i];
        end else begin
          cnt[i]    <= cnt[i] + ONE;
          tick[i]   <= 1'b0;
        end
      end
    end
  end

  // Pending-slot occupancy and invalid-channel error strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      load_err <= 1'b0;
    end else begin
      load_err <= accept & ch_bad;
      if (accept && !ch_bad) begin
        pend_vld <= 1'b1;
      end else if (|apply) begin
        pend_vld <= 1'b0;
      end
    end
  end

  // Pending-slot payload; only meaningful while pend_vld is set.
  always_ff @(posedge clk) begin
    if (accept && !ch_bad) begin
      pend_ch   <= load_ch;
      pend_half <= clamp_half(load_half);
    end
  end

endmodule
